// File: rtl/simd_alu_issue_ctrl_if.sv
// Request / ALU / response bundle for the SIMD ALU issue front end.
// Both req_* and rsp_* are valid/ready: a beat transfers on the clock edge where valid && ready,
// and the sender holds valid and its payload stable until that edge.
interface simd_alu_issue_ctrl_if #(
    parameter int DATA_W = 256,
    parameter int OPC_W  = 5,
    parameter int TAG_W  = 4
);
    localparam int BYTES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OPC_W-1:0]  req_opcode;
    logic [TAG_W-1:0]  req_tag;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OPC_W-1:0]  alu_opcode;
    logic [DATA_W-1:0] alu_out;
    logic [BYTES-1:0]  alu_ovf;
    logic [BYTES-1:0]  alu_udf;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [BYTES-1:0]  rsp_ovf;
    logic [BYTES-1:0]  rsp_udf;
    logic [TAG_W-1:0]  rsp_tag;

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, req_tag,
        output req_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_out, alu_ovf, alu_udf,
        output rsp_valid, rsp_data, rsp_ovf, rsp_udf, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_opcode, req_tag,
        input  req_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_out, alu_ovf, alu_udf,
        input  rsp_valid, rsp_data, rsp_ovf, rsp_udf, rsp_tag,
        output rsp_ready
    );
endinterface

// File: rtl/simd_alu_issue_ctrl.sv
// Issue controller for simd_alu_top: request FIFO, one-op-at-a-time ALU drive, and a
// tagged response register with backpressure.
module simd_alu_issue_ctrl #(
    parameter int DATA_W     = 256,
    parameter int OPC_W      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1,
    parameter int TAG_W      = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    simd_alu_issue_ctrl_if.slave bus,
    output logic [LVL_W-1:0]     fifo_level_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ALU_LAT - 1);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OPC_W-1:0]  opc;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    req_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;
    req_t             head;

    state_e            state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [TAG_W-1:0]  op_tag_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [OPC_W-1:0]  alu_opc_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [BYTES-1:0]  rsp_ovf_q, rsp_udf_q;
    logic [TAG_W-1:0]  rsp_tag_q;

    assign full  = (count_q == FULL_LVL);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // No pass-through when full: ready depends only on the registered level.
    assign bus.req_ready = rst_n && !full;
    assign push = bus.req_valid && bus.req_ready;
    assign pop  = !empty && ((state_q == S_IDLE) || (state_q == S_RESP && bus.rsp_ready));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.req_a, bus.req_b, bus.req_opcode, bus.req_tag};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ALU operands change only on a pop, so they hold from ISSUE through the capture edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            op_tag_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_opc_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= '0;
            rsp_udf_q   <= '0;
            rsp_tag_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        alu_a_q   <= head.a;
                        alu_b_q   <= head.b;
                        alu_opc_q <= head.opc;
                        op_tag_q  <= head.tag;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_q <= WAIT_INIT;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        rsp_data_q  <= bus.alu_out;
                        rsp_ovf_q   <= bus.alu_ovf;
                        rsp_udf_q   <= bus.alu_udf;
                        rsp_tag_q   <= op_tag_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (pop) begin
                            alu_a_q   <= head.a;
                            alu_b_q   <= head.b;
                            alu_opc_q <= head.opc;
                            op_tag_q  <= head.tag;
                            state_q   <= S_ISSUE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_opc_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.rsp_udf    = rsp_udf_q;
    assign bus.rsp_tag    = rsp_tag_q;

    assign fifo_level_o = count_q;
    assign busy_o       = (state_q != S_IDLE) || !empty;
    assign state_o      = state_q;
endmodule

// File: tb/tb_simd_alu_issue_ctrl.sv
// Bench for simd_alu_issue_ctrl: behavioural byte-lane ALU stub, queue scoreboard and monitor.
module tb_simd_alu_issue_ctrl;
    localparam int DATA_W     = 256;
    localparam int OPC_W      = 5;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int ALU_LAT    = 1;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int BYTES      = DATA_W / 8;

    localparam logic [OPC_W-1:0] OP_ADD = 5'd1;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd2;
    localparam logic [OPC_W-1:0] OP_LSL = 5'd3;
    localparam logic [OPC_W-1:0] OP_CMP = 5'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BYTES-1:0]  ovf;
        logic [BYTES-1:0]  udf;
    } alu_res_t;

    typedef struct packed {
        alu_res_t         res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simd_alu_issue_ctrl_if #(.DATA_W(DATA_W), .OPC_W(OPC_W), .TAG_W(TAG_W)) bus ();
    logic [LVL_W-1:0] fifo_level;
    logic             busy;
    logic [1:0]       state_dbg;

    simd_alu_issue_ctrl #(
        .DATA_W(DATA_W), .OPC_W(OPC_W), .FIFO_DEPTH(FIFO_DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .fifo_level_o(fifo_level),
        .busy_o(busy),
        .state_o(state_dbg)
    );

    logic [EXP_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_push_cyc = 0;
    int last_hs = -1;
    bit chk_gap = 0;
    bit rst_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_edge = !rst_n;

    // Byte-lane reference ALU: carry-out, borrow, shifted-out bits and equality per lane.
    function automatic alu_res_t alu_model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                           input logic [OPC_W-1:0] opc);
        alu_res_t r;
        logic [7:0] x, y;
        logic [8:0] s;
        logic [15:0] w;
        r = '0;
        for (int i = 0; i < BYTES; i++) begin
            x = a[8*i +: 8];
            y = b[8*i +: 8];
            case (opc)
                OP_ADD: begin
                    s = {1'b0, x} + {1'b0, y};
                    r.data[8*i +: 8] = s[7:0];
                    r.ovf[i] = s[8];
                end
                OP_SUB: begin
                    r.data[8*i +: 8] = x - y;
                    r.udf[i] = (x < y);
                end
                OP_LSL: begin
                    w = {8'h00, x} << y[2:0];
                    r.data[8*i +: 8] = w[7:0];
                    r.ovf[i] = |w[15:8];
                end
                OP_CMP: r.data[8*i +: 8] = (x == y) ? 8'hFF : 8'h00;
                default: ;
            endcase
        end
        return r;
    endfunction

    // ALU stub: registers its inputs on the edge closing ISSUE, result valid one cycle later.
    always @(posedge clk) begin
        {bus.alu_out, bus.alu_ovf, bus.alu_udf} <= alu_model(bus.alu_a, bus.alu_b, bus.alu_opcode);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[32*i +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] near_copy(input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = a;
        for (int i = 0; i < BYTES; i++)
            if ($urandom_range(0, 1) == 1) w[8*i +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    task automatic send(input logic [OPC_W-1:0] opc, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag);
        int n;
        exp_t e;
        bus.req_valid  = 1'b1;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_opcode = opc;
        bus.req_tag    = tag;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: got no req_ready want req_ready within 300 cycles");
        end else begin
            e.res = alu_model(a, b, opc);
            e.tag = tag;
            exp_q.push_back(EXP_W'(e));
            last_push_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n >= 500), 64'd0);
    endtask

    // Monitor: scoreboard pops, response hold under backpressure, ALU operand stability.
    logic             prev_ok = 1'b0;
    logic             prev_hold;
    logic [1:0]       prev_st;
    logic [DATA_W-1:0] prev_a, prev_b, prev_data;
    logic [OPC_W-1:0] prev_opc;
    logic [BYTES-1:0] prev_ovf, prev_udf;
    logic [TAG_W-1:0] prev_tag;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || rst_edge) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && prev_hold) begin
                check("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
                check_wide("rsp_hold_data", bus.rsp_data, prev_data);
                check("rsp_hold_ovf", 64'(bus.rsp_ovf), 64'(prev_ovf));
                check("rsp_hold_udf", 64'(bus.rsp_udf), 64'(prev_udf));
                check("rsp_hold_tag", 64'(bus.rsp_tag), 64'(prev_tag));
            end
            if (prev_ok && (prev_st == ST_ISSUE || prev_st == ST_WAIT)) begin
                check_wide("alu_a_stable", bus.alu_a, prev_a);
                check_wide("alu_b_stable", bus.alu_b, prev_b);
                check("alu_opc_stable", 64'(bus.alu_opcode), 64'(prev_opc));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got tag %0h want no response", bus.rsp_tag);
                end else begin
                    e = exp_t'(exp_q.pop_front());
                    check_wide("rsp_data", bus.rsp_data, e.res.data);
                    check("rsp_ovf", 64'(bus.rsp_ovf), 64'(e.res.ovf));
                    check("rsp_udf", 64'(bus.rsp_udf), 64'(e.res.udf));
                    check("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
                end
                if (chk_gap) begin
                    if (last_hs >= 0) check("rsp_gap", 64'(cyc - last_hs), 64'd3);
                    last_hs = cyc;
                end
            end
            prev_ok   = 1'b1;
            prev_st   = state_dbg;
            prev_hold = bus.rsp_valid && !bus.rsp_ready;
            prev_a    = bus.alu_a;
            prev_b    = bus.alu_b;
            prev_opc  = bus.alu_opcode;
            prev_data = bus.rsp_data;
            prev_ovf  = bus.rsp_ovf;
            prev_udf  = bus.rsp_udf;
            prev_tag  = bus.rsp_tag;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000 time units");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [DATA_W-1:0] a, b;
        logic [OPC_W-1:0] opc;
        bit rnd_done;

        // Reset with a request pending: nothing may be accepted.
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_a      = rand_word();
        bus.req_b      = rand_word();
        bus.req_opcode = OP_ADD;
        bus.req_tag    = 4'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_wide("rst_alu_a", bus.alu_a, '0);
        check_wide("rst_alu_b", bus.alu_b, '0);
        check("rst_alu_opc", 64'(bus.alu_opcode), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_level", 64'(fifo_level), 64'd0);
        check("post_rst_ready", 64'(bus.req_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_state", 64'(state_dbg), 64'(ST_IDLE));
        @(posedge clk);
        #1;

        // Single ADD8, latency from push edge.
        bus.rsp_ready = 1'b1;
        send(OP_ADD, {BYTES{8'h01}}, {BYTES{8'h02}}, 4'd3);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("add8_latency", 64'(cyc - last_push_cyc), 64'd3);
        check_wide("add8_data", bus.rsp_data, {BYTES{8'h03}});
        check("add8_ovf", 64'(bus.rsp_ovf), 64'd0);
        check("add8_tag", 64'(bus.rsp_tag), 64'd3);
        @(posedge clk);
        #1;
        wait_idle();
        @(posedge clk);
        #1;

        // Backpressure: fill the FIFO behind one op held in RESP.
        bus.rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++) send(OP_SUB, rand_word(), rand_word(), 4'(t));
        bus.req_valid  = 1'b1;
        bus.req_a      = rand_word();
        bus.req_b      = rand_word();
        bus.req_opcode = OP_LSL;
        bus.req_tag    = 4'd5;
        @(negedge clk);
        check("full_req_ready", 64'(bus.req_ready), 64'd0);
        check("full_level", 64'(fifo_level), 64'd4);
        check("full_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        send(OP_LSL, bus.req_a, bus.req_b, 4'd5);
        wait_idle();
        @(posedge clk);
        #1;

        // Throughput: 8 ops, ready held high, one response every 3 cycles.
        chk_gap = 1;
        last_hs = -1;
        for (int t = 0; t < 8; t++) begin
            a = rand_word();
            case (t % 4)
                0: opc = OP_ADD;
                1: opc = OP_SUB;
                2: opc = OP_LSL;
                default: opc = OP_CMP;
            endcase
            b = (opc == OP_CMP) ? near_copy(a) : rand_word();
            send(opc, a, b, 4'(t));
        end
        wait_idle();
        chk_gap = 0;
        @(posedge clk);
        #1;

        // Randomised traffic with random backpressure and unknown opcodes.
        rnd_done = 0;
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int t = 0; t < 40; t++) begin
                    a = rand_word();
                    opc = 5'($urandom_range(0, 7));
                    b = (opc == OP_CMP) ? near_copy(a) : rand_word();
                    send(opc, a, b, 4'($urandom_range(0, 15)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1;
            end
        join
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_idle();
        @(posedge clk);
        #1;

        // Reset while in WAIT with two ops queued: all of it is discarded.
        for (int t = 0; t < 3; t++) send(OP_ADD, rand_word(), rand_word(), 4'(10 + t));
        n = 0;
        while (!(state_dbg == ST_WAIT && fifo_level == 2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_wait", 64'(state_dbg == ST_WAIT && fifo_level == 2), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
